// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Frame constants and sum type shared by the serial adder tree
//               and its downstream sum collector.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

  localparam int SER_FRAME         = 8;
  localparam int SUM_CAPTURE_PHASE = 4;
  localparam int SUM_PRIME_FRAMES  = 3;

  typedef logic [7:0] sum_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers; accepts a push when
//               full if a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int c_aw = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic          w_wr_en;
  logic          w_rd_en;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_rd_en = pop & ~empty;
  // When full, the slot being written is the one the pop frees this edge.
  assign w_wr_en = push & (~full | w_rd_en);
  assign level   = r_wr_ptr - r_rd_ptr;
  assign dout    = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mem    <= '{default: '0};
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[c_aw-1:0]] <= din;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sum_collector.sv
`default_nettype none
// ============================================================================
// Module      : sum_collector
// Description : Samples the adder tree sum once per frame after pipeline fill
//               and streams the samples out through a FIFO with drop counting.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_collector
  import sa_pkg::*;
#(
  parameter int W             = $bits(sum_t),
  parameter int FRAME         = SER_FRAME,
  parameter int CAPTURE_PHASE = SUM_CAPTURE_PHASE,
  parameter int PRIME_FRAMES  = SUM_PRIME_FRAMES,
  parameter int DEPTH         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           q,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int c_phase_w = $clog2(FRAME);
  localparam int c_prime_w = ($clog2(PRIME_FRAMES + 1) > 0) ? $clog2(PRIME_FRAMES + 1) : 1;
  localparam logic [c_phase_w-1:0] c_cap_phase = c_phase_w'(CAPTURE_PHASE);
  localparam logic [c_prime_w-1:0] c_prime_max = c_prime_w'(PRIME_FRAMES);

  logic [c_phase_w-1:0] r_phase;
  logic [c_prime_w-1:0] r_prime_cnt;
  logic                 r_overflow;
  logic [7:0]           r_drop_cnt;

  logic w_capture;
  logic w_primed;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;

  assign w_capture = (r_phase == c_cap_phase);
  assign w_primed  = (r_prime_cnt == c_prime_max);
  assign w_push    = w_capture & w_primed;
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = w_push & w_full & ~w_pop;

  assign out_valid = ~w_empty;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

  // Phase wraps naturally since FRAME is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase     <= '0;
      r_prime_cnt <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      r_phase <= r_phase + 1'b1;
      if (w_capture && !w_primed) begin
        r_prime_cnt <= r_prime_cnt + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (q),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

endmodule
`default_nettype wire
